// File: rtl/flag_ctx.sv
// Flag context controller: latches ALU flags into normal/interrupt banks, sequences
// interrupt entry/return and evaluates branch conditions on the active bank.
module flag_ctx #(
  parameter int unsigned MASK_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       carry_in,
  input  logic       zero_in,
  input  logic       overflow_in,
  input  logic       flag_we,
  input  logic       irq_req,
  input  logic       iret,
  input  logic [2:0] cond_sel,
  output logic       interruption,
  output logic       irq_ack,
  output logic       carry,
  output logic       zero,
  output logic       overflow,
  output logic       take_branch
);

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_ACK = 2'd1,
    ST_ISR = 2'd2,
    ST_RET = 2'd3
  } state_t;

  localparam logic [3:0] MASK_LOAD = 4'(MASK_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] mask_q, mask_d;
  // Bank layout is {C, Z, V}.
  logic [2:0] nbank_q, nbank_d;
  logic [2:0] ibank_q, ibank_d;
  logic [2:0] act_q, act_d;
  logic       irq_ack_q, irq_ack_d;
  logic       intr_q, intr_d;
  logic [2:0] flags_in_s;

  assign flags_in_s = {carry_in, zero_in, overflow_in};

  // Next-state and interrupt mask sequencing.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    case (state_q)
      ST_RUN: begin
        if (mask_q != 4'd0) begin
          mask_d = mask_q - 4'd1;
        end else if (irq_req) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_ACK: state_d = ST_ISR;
      ST_ISR: begin
        if (iret) begin
          state_d = ST_RET;
        end else begin
          state_d = ST_ISR;
        end
      end
      ST_RET: begin
        state_d = ST_RUN;
        mask_d  = MASK_LOAD;
      end
      default: begin
        state_d = ST_RUN;
        mask_d  = 4'd0;
      end
    endcase
  end

  // Bank updates; the ACK-cycle instruction still belongs to the normal context.
  always_comb begin
    nbank_d = nbank_q;
    ibank_d = ibank_q;
    if (state_q == ST_ACK) begin
      ibank_d = 3'b000;
    end else begin
      ibank_d = ibank_q;
    end
    if (flag_we) begin
      if (state_q == ST_ISR) begin
        ibank_d = flags_in_s;
      end else begin
        nbank_d = flags_in_s;
      end
    end else begin
      nbank_d = nbank_q;
    end
  end

  // Registered outputs are precomputed from the next state so they align with it.
  always_comb begin
    irq_ack_d = (state_d == ST_ACK);
    intr_d    = (state_d == ST_ISR);
    if (state_d == ST_ISR) begin
      act_d = ibank_d;
    end else begin
      act_d = nbank_d;
    end
  end

  // State, banks and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      mask_q    <= 4'd0;
      nbank_q   <= 3'b000;
      ibank_q   <= 3'b000;
      act_q     <= 3'b000;
      irq_ack_q <= 1'b0;
      intr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      nbank_q   <= nbank_d;
      ibank_q   <= ibank_d;
      act_q     <= act_d;
      irq_ack_q <= irq_ack_d;
      intr_q    <= intr_d;
    end
  end

  assign interruption = intr_q;
  assign irq_ack      = irq_ack_q;
  assign carry        = act_q[2];
  assign zero         = act_q[1];
  assign overflow     = act_q[0];

  // Branch condition evaluation on the active bank.
  always_comb begin
    take_branch = 1'b0;
    case (cond_sel)
      3'b000:  take_branch = 1'b1;
      3'b001:  take_branch = act_q[1];
      3'b010:  take_branch = ~act_q[1];
      3'b011:  take_branch = act_q[2];
      3'b100:  take_branch = ~act_q[2];
      3'b101:  take_branch = act_q[0];
      3'b110:  take_branch = ~act_q[0];
      3'b111:  take_branch = 1'b0;
      default: take_branch = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_flag_ctx.sv
// Directed testbench for flag_ctx; a second instance with MASK_CYCLES=0 shares all inputs.
module tb_flag_ctx;

  logic       clk = 1'b0;
  logic       reset;
  logic       carry_in, zero_in, overflow_in, flag_we, irq_req, iret;
  logic [2:0] cond_sel;
  logic       interruption, irq_ack, carry, zero, overflow, take_branch;
  logic       int0, ack0, c0, z0, v0, tb0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  flag_ctx #(.MASK_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .carry_in(carry_in), .zero_in(zero_in),
    .overflow_in(overflow_in), .flag_we(flag_we), .irq_req(irq_req), .iret(iret),
    .cond_sel(cond_sel), .interruption(interruption), .irq_ack(irq_ack),
    .carry(carry), .zero(zero), .overflow(overflow), .take_branch(take_branch)
  );

  flag_ctx #(.MASK_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .carry_in(carry_in), .zero_in(zero_in),
    .overflow_in(overflow_in), .flag_we(flag_we), .irq_req(irq_req), .iret(iret),
    .cond_sel(cond_sel), .interruption(int0), .irq_ack(ack0),
    .carry(c0), .zero(z0), .overflow(v0), .take_branch(tb0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [2:0] f);
    {carry_in, zero_in, overflow_in} = f;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flag_we = 1'b0; irq_req = 1'b0; iret = 1'b0; cond_sel = 3'b000;
    set_flags(3'b000);
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({interruption, irq_ack, carry, zero, overflow} !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_state: got %b expected 00000", {interruption, irq_ack, carry, zero, overflow});
    end
    flag_we = 1'b1; set_flags(3'b100);
    tick();
    flag_we = 1'b0;
    n_vec++;
    if ({carry, zero, overflow} !== 3'b100) begin
      n_err++;
      $display("FAIL write_n: got %b expected 100", {carry, zero, overflow});
    end
    cond_sel = 3'b011; #1;
    n_vec++;
    if (take_branch !== 1'b1) begin
      n_err++;
      $display("FAIL branch_c: got %b expected 1", take_branch);
    end
    cond_sel = 3'b100; #1;
    n_vec++;
    if (take_branch !== 1'b0) begin
      n_err++;
      $display("FAIL branch_nc: got %b expected 0", take_branch);
    end
  endtask

  task automatic test_irq_entry();
    flag_we = 1'b1; set_flags(3'b110);
    tick();
    flag_we = 1'b0;
    irq_req = 1'b1;
    tick();
    irq_req = 1'b0;
    n_vec++;
    if ({irq_ack, interruption} !== 2'b10) begin
      n_err++;
      $display("FAIL ack_cycle: got ack/int %b expected 10", {irq_ack, interruption});
    end
    tick();
    n_vec++;
    if ({irq_ack, interruption, carry, zero} !== 4'b0100) begin
      n_err++;
      $display("FAIL isr_entry: got ack/int/c/z %b expected 0100", {irq_ack, interruption, carry, zero});
    end
    flag_we = 1'b1; set_flags(3'b010);
    tick();
    flag_we = 1'b0;
    n_vec++;
    if ({interruption, carry, zero} !== 3'b101) begin
      n_err++;
      $display("FAIL isr_write: got int/c/z %b expected 101", {interruption, carry, zero});
    end
    iret = 1'b1;
    tick();
    iret = 1'b0;
    n_vec++;
    if ({interruption, carry, zero} !== 3'b011) begin
      n_err++;
      $display("FAIL iret_restore: got int/c/z %b expected 011", {interruption, carry, zero});
    end
    tick();
    tick();
  endtask

  task automatic test_mask();
    logic [1:0] exp1 [7];
    logic [1:0] exp0 [7];
    exp1 = '{2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    exp0 = '{2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b01};
    do_reset();
    irq_req = 1'b1;
    for (int t = 0; t < 7; t++) begin
      iret = (t == 3);
      tick();
      n_vec++;
      if ({irq_ack, interruption} !== exp1[t]) begin
        n_err++;
        $display("FAIL mask1_seq[%0d]: got ack/int %b expected %b", t, {irq_ack, interruption}, exp1[t]);
      end
      n_vec++;
      if ({ack0, int0} !== exp0[t]) begin
        n_err++;
        $display("FAIL mask0_seq[%0d]: got ack/int %b expected %b", t, {ack0, int0}, exp0[t]);
      end
    end
    iret = 1'b0;
    irq_req = 1'b0;
    do_reset();
  endtask

  task automatic test_ack_write();
    irq_req = 1'b1;
    tick();
    irq_req = 1'b0;
    flag_we = 1'b1; set_flags(3'b001);
    tick();
    flag_we = 1'b0;
    n_vec++;
    if ({interruption, overflow} !== 2'b10) begin
      n_err++;
      $display("FAIL ack_write_i: got int/v %b expected 10", {interruption, overflow});
    end
    iret = 1'b1;
    tick();
    iret = 1'b0;
    n_vec++;
    if ({interruption, carry, zero, overflow} !== 4'b0001) begin
      n_err++;
      $display("FAIL ack_write_n: got int/czv %b expected 0001", {interruption, carry, zero, overflow});
    end
    tick();
    tick();
    iret = 1'b1;
    tick();
    iret = 1'b0;
    n_vec++;
    if ({interruption, irq_ack, carry, zero, overflow} !== 5'b00001) begin
      n_err++;
      $display("FAIL iret_in_run: got %b expected 00001", {interruption, irq_ack, carry, zero, overflow});
    end
    // Write with iret in ISR: lands in I bank, N must be unchanged after exit.
    irq_req = 1'b1;
    tick();
    irq_req = 1'b0;
    tick();
    flag_we = 1'b1; iret = 1'b1; set_flags(3'b111);
    tick();
    flag_we = 1'b0; iret = 1'b0;
    n_vec++;
    if ({interruption, carry, zero, overflow} !== 4'b0001) begin
      n_err++;
      $display("FAIL iret_write: got int/czv %b expected 0001", {interruption, carry, zero, overflow});
    end
    tick();
    tick();
  endtask

  task automatic test_reset_in_isr();
    irq_req = 1'b1;
    tick();
    irq_req = 1'b0;
    tick();
    flag_we = 1'b1; set_flags(3'b010);
    tick();
    flag_we = 1'b0;
    n_vec++;
    if ({interruption, zero} !== 2'b11) begin
      n_err++;
      $display("FAIL isr_pre_reset: got int/z %b expected 11", {interruption, zero});
    end
    reset = 1'b1;
    #2;
    n_vec++;
    if ({interruption, irq_ack, carry, zero, overflow} !== 5'b00000) begin
      n_err++;
      $display("FAIL async_reset: got %b expected 00000", {interruption, irq_ack, carry, zero, overflow});
    end
    reset = 1'b0;
    tick();
    irq_req = 1'b1;
    tick();
    irq_req = 1'b0;
    n_vec++;
    if ({irq_ack, interruption} !== 2'b10) begin
      n_err++;
      $display("FAIL run_after_reset: got ack/int %b expected 10", {irq_ack, interruption});
    end
    do_reset();
  endtask

  task automatic test_cond_sweep();
    logic [2:0] f;
    logic       exp_b;
    for (int fi = 0; fi < 8; fi++) begin
      f = 3'(fi);
      flag_we = 1'b1; set_flags(f);
      tick();
      flag_we = 1'b0;
      n_vec++;
      if ({carry, zero, overflow} !== f) begin
        n_err++;
        $display("FAIL sweep_flags: got %b expected %b", {carry, zero, overflow}, f);
      end
      for (int s = 0; s < 8; s++) begin
        cond_sel = 3'(s);
        case (s)
          0: exp_b = 1'b1;
          1: exp_b = f[1];
          2: exp_b = !f[1];
          3: exp_b = f[2];
          4: exp_b = !f[2];
          5: exp_b = f[0];
          6: exp_b = !f[0];
          default: exp_b = 1'b0;
        endcase
        #1;
        n_vec++;
        if (take_branch !== exp_b) begin
          n_err++;
          $display("FAIL cond_sweep flags=%b sel=%0d: got %b expected %b", f, s, take_branch, exp_b);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_irq_entry();
    test_mask();
    test_ack_write();
    test_reset_in_isr();
    test_cond_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
